// File: rtl/rv32i_exec_stage.sv
// Multi-cycle RV32I execute stage: register read, ALU, branch/jump resolution, writeback, next PC.
// Optional RV32I_SERIAL_SHIFT_EN: shifts run one bit per cycle in a SHIFT state instead of a barrel shifter.
module rv32i_exec_stage #(
  parameter int unsigned DBG_REG = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] instr_pc,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [31:0] next_pc,
  output logic        next_pc_valid,
  output logic        halted,
  output logic        wb_we,
  output logic [4:0]  wb_id,
  output logic [31:0] wb_data,
  output logic [31:0] dbg_reg
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [4:0] DBG_IDX   = 5'(DBG_REG);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_EXEC  = 3'd2,
`ifdef RV32I_SERIAL_SHIFT_EN
    S_SHIFT = 3'd3,
`endif
    S_WB    = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] instr_r, pc_r, rs1_r, rs2_r;
  logic [31:0] regs_r [32];
  logic [31:0] next_pc_r, wb_data_r;
  logic        next_pc_valid_r, halted_r, wb_we_r;
  logic [4:0]  wb_id_r;

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [4:0]  rd_s, rs1_id_s, rs2_id_s, shamt_s;
  logic [31:0] imm_i_s, imm_u_s, imm_b_s, imm_j_s, pc_plus4_s;
  logic [31:0] op2_s, alu_s, wb_val_s, npc_s;
  logic        taken_s, writes_rd_s, supported_s;

  assign opcode_s   = instr_r[6:0];
  assign rd_s       = instr_r[11:7];
  assign funct3_s   = instr_r[14:12];
  assign rs1_id_s   = instr_r[19:15];
  assign rs2_id_s   = instr_r[24:20];
  assign imm_i_s    = {{20{instr_r[31]}}, instr_r[31:20]};
  assign imm_u_s    = {instr_r[31:12], 12'd0};
  assign imm_b_s    = {{20{instr_r[31]}}, instr_r[7], instr_r[30:25], instr_r[11:8], 1'b0};
  assign imm_j_s    = {{12{instr_r[31]}}, instr_r[19:12], instr_r[20], instr_r[30:21], 1'b0};
  assign pc_plus4_s = pc_r + 32'd4;
  assign shamt_s    = op2_s[4:0];

`ifdef RV32I_SERIAL_SHIFT_EN
  logic [31:0] sh_val_r, sh_next_s;
  logic [4:0]  sh_cnt_r;
  logic        is_shift_s;

  assign is_shift_s = ((opcode_s == OP_IMM) || (opcode_s == OP_REG)) && (funct3_s[1:0] == 2'b01);

  // one-bit step of the serial shifter
  always_comb begin
    sh_next_s = sh_val_r;
    if (funct3_s[2] == 1'b0) begin
      sh_next_s = {sh_val_r[30:0], 1'b0};
    end else if (instr_r[30]) begin
      sh_next_s = {sh_val_r[31], sh_val_r[31:1]};
    end else begin
      sh_next_s = {1'b0, sh_val_r[31:1]};
    end
  end
`endif

  // ALU
  always_comb begin
    op2_s = imm_i_s;
    if (opcode_s == OP_REG) begin
      op2_s = rs2_r;
    end else begin
      op2_s = imm_i_s;
    end
    alu_s = 32'd0;
    case (funct3_s)
      3'b000: begin
        if ((opcode_s == OP_REG) && instr_r[30]) begin
          alu_s = rs1_r - op2_s;
        end else begin
          alu_s = rs1_r + op2_s;
        end
      end
`ifdef RV32I_SERIAL_SHIFT_EN
      // zero-amount result; non-zero amounts go through SHIFT
      3'b001: alu_s = rs1_r;
      3'b101: alu_s = rs1_r;
`else
      3'b001: alu_s = rs1_r << shamt_s;
      3'b101: begin
        if (instr_r[30]) begin
          alu_s = $unsigned($signed(rs1_r) >>> shamt_s);
        end else begin
          alu_s = rs1_r >> shamt_s;
        end
      end
`endif
      3'b010: alu_s = {31'd0, ($signed(rs1_r) < $signed(op2_s))};
      3'b011: alu_s = {31'd0, (rs1_r < op2_s)};
      3'b100: alu_s = rs1_r ^ op2_s;
      3'b110: alu_s = rs1_r | op2_s;
      3'b111: alu_s = rs1_r & op2_s;
      default: alu_s = 32'd0;
    endcase
  end

  // branch condition
  always_comb begin
    taken_s = 1'b0;
    case (funct3_s)
      3'b000: taken_s = (rs1_r == rs2_r);
      3'b001: taken_s = (rs1_r != rs2_r);
      3'b100: taken_s = ($signed(rs1_r) < $signed(rs2_r));
      3'b101: taken_s = ($signed(rs1_r) >= $signed(rs2_r));
      3'b110: taken_s = (rs1_r < rs2_r);
      3'b111: taken_s = (rs1_r >= rs2_r);
      default: taken_s = 1'b0;
    endcase
  end

  // writeback value, next PC and opcode support
  always_comb begin
    wb_val_s    = alu_s;
    npc_s       = pc_plus4_s;
    writes_rd_s = 1'b0;
    supported_s = 1'b1;
    case (opcode_s)
      OP_LUI:   begin wb_val_s = imm_u_s;        writes_rd_s = 1'b1; end
      OP_AUIPC: begin wb_val_s = pc_r + imm_u_s; writes_rd_s = 1'b1; end
      OP_JAL: begin
        wb_val_s    = pc_plus4_s;
        npc_s       = pc_r + imm_j_s;
        writes_rd_s = 1'b1;
      end
      OP_JALR: begin
        wb_val_s    = pc_plus4_s;
        npc_s       = (rs1_r + imm_i_s) & 32'hFFFF_FFFE;
        writes_rd_s = 1'b1;
      end
      OP_BRANCH: begin
        if (taken_s) begin
          npc_s = pc_r + imm_b_s;
        end else begin
          npc_s = pc_plus4_s;
        end
      end
      OP_IMM, OP_REG: writes_rd_s = 1'b1;
      default: supported_s = 1'b0;
    endcase
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (instr_valid) state_s = S_READ;
        else             state_s = S_IDLE;
      end
      S_READ: begin
        if (supported_s) state_s = S_EXEC;
        else             state_s = S_HALT;
      end
`ifdef RV32I_SERIAL_SHIFT_EN
      S_EXEC: begin
        if (is_shift_s && (shamt_s != 5'd0)) state_s = S_SHIFT;
        else                                 state_s = S_WB;
      end
      S_SHIFT: begin
        if (sh_cnt_r == 5'd1) state_s = S_WB;
        else                  state_s = S_SHIFT;
      end
`else
      S_EXEC: state_s = S_WB;
`endif
      S_WB:   state_s = S_IDLE;
      S_HALT: state_s = S_HALT;
      default: state_s = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_r <= S_IDLE;
    else       state_r <= state_s;
  end

  // datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_r         <= 32'd0;
      pc_r            <= 32'd0;
      rs1_r           <= 32'd0;
      rs2_r           <= 32'd0;
      next_pc_r       <= 32'd0;
      next_pc_valid_r <= 1'b0;
      halted_r        <= 1'b0;
      wb_we_r         <= 1'b0;
      wb_id_r         <= 5'd0;
      wb_data_r       <= 32'd0;
`ifdef RV32I_SERIAL_SHIFT_EN
      sh_val_r        <= 32'd0;
      sh_cnt_r        <= 5'd0;
`endif
    end else begin
      wb_we_r         <= 1'b0;
      next_pc_valid_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (instr_valid) begin
            instr_r <= instr;
            pc_r    <= instr_pc;
          end
        end
        S_READ: begin
          rs1_r <= (rs1_id_s == 5'd0) ? 32'd0 : regs_r[rs1_id_s];
          rs2_r <= (rs2_id_s == 5'd0) ? 32'd0 : regs_r[rs2_id_s];
          if (!supported_s) halted_r <= 1'b1;
        end
        S_EXEC: begin
`ifdef RV32I_SERIAL_SHIFT_EN
          sh_val_r <= rs1_r;
          sh_cnt_r <= shamt_s;
`endif
          if (state_s == S_WB) begin
            wb_we_r         <= writes_rd_s && (rd_s != 5'd0);
            wb_id_r         <= rd_s;
            wb_data_r       <= wb_val_s;
            next_pc_r       <= npc_s;
            next_pc_valid_r <= 1'b1;
          end
        end
`ifdef RV32I_SERIAL_SHIFT_EN
        S_SHIFT: begin
          sh_val_r <= sh_next_s;
          sh_cnt_r <= sh_cnt_r - 5'd1;
          if (sh_cnt_r == 5'd1) begin
            wb_we_r         <= (rd_s != 5'd0);
            wb_id_r         <= rd_s;
            wb_data_r       <= sh_next_s;
            next_pc_r       <= pc_plus4_s;
            next_pc_valid_r <= 1'b1;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

  // register file; contents survive reset, an in-flight write is dropped by it
  always_ff @(posedge clk) begin
    if (!reset && (state_r == S_WB) && wb_we_r) begin
      regs_r[wb_id_r] <= wb_data_r;
    end
  end

  assign instr_ready   = (state_r == S_IDLE) && !reset;
  assign next_pc       = next_pc_r;
  assign next_pc_valid = next_pc_valid_r;
  assign halted        = halted_r;
  assign wb_we         = wb_we_r;
  assign wb_id         = wb_id_r;
  assign wb_data       = wb_data_r;
  assign dbg_reg       = (DBG_IDX == 5'd0) ? 32'd0 : regs_r[DBG_IDX];

endmodule

// File: tb/tb_rv32i_exec_stage.sv
// Self-checking bench for rv32i_exec_stage: directed cases plus random instructions against an ISA-level model.
module tb_rv32i_exec_stage;

  logic        clk = 1'b0;
  logic        reset, instr_valid, instr_ready, next_pc_valid, halted, wb_we;
  logic [31:0] instr, instr_pc, next_pc, wb_data, dbg_reg;
  logic [4:0]  wb_id;

  always #5 clk = ~clk;

  rv32i_exec_stage #(.DBG_REG(1)) dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .next_pc(next_pc), .next_pc_valid(next_pc_valid), .halted(halted),
    .wb_we(wb_we), .wb_id(wb_id), .wb_data(wb_data), .dbg_reg(dbg_reg)
  );

  localparam int K_ADD = 0, K_SUB = 1, K_SLL = 2, K_SLT = 3, K_SLTU = 4, K_XOR = 5,
                 K_SRL = 6, K_SRA = 7, K_OR = 8, K_AND = 9, K_ADDI = 10, K_SLTI = 11,
                 K_SLTIU = 12, K_XORI = 13, K_ORI = 14, K_ANDI = 15, K_SLLI = 16,
                 K_SRLI = 17, K_SRAI = 18, K_LUI = 19, K_AUIPC = 20, K_JAL = 21,
                 K_JALR = 22, K_BEQ = 23, K_BNE = 24, K_BLT = 25, K_BGE = 26,
                 K_BLTU = 27, K_BGEU = 28;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] mregs [32];
  logic [31:0] obs_npc, obs_data;
  logic        obs_we;
  int          obs_lat;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] encode(input int k, input logic [4:0] rd, rs1, rs2,
                                         input logic [31:0] imm);
    case (k)
      K_ADD:   return {7'h00, rs2, rs1, 3'd0, rd, 7'h33};
      K_SUB:   return {7'h20, rs2, rs1, 3'd0, rd, 7'h33};
      K_SLL:   return {7'h00, rs2, rs1, 3'd1, rd, 7'h33};
      K_SLT:   return {7'h00, rs2, rs1, 3'd2, rd, 7'h33};
      K_SLTU:  return {7'h00, rs2, rs1, 3'd3, rd, 7'h33};
      K_XOR:   return {7'h00, rs2, rs1, 3'd4, rd, 7'h33};
      K_SRL:   return {7'h00, rs2, rs1, 3'd5, rd, 7'h33};
      K_SRA:   return {7'h20, rs2, rs1, 3'd5, rd, 7'h33};
      K_OR:    return {7'h00, rs2, rs1, 3'd6, rd, 7'h33};
      K_AND:   return {7'h00, rs2, rs1, 3'd7, rd, 7'h33};
      K_ADDI:  return {imm[11:0], rs1, 3'd0, rd, 7'h13};
      K_SLTI:  return {imm[11:0], rs1, 3'd2, rd, 7'h13};
      K_SLTIU: return {imm[11:0], rs1, 3'd3, rd, 7'h13};
      K_XORI:  return {imm[11:0], rs1, 3'd4, rd, 7'h13};
      K_ORI:   return {imm[11:0], rs1, 3'd6, rd, 7'h13};
      K_ANDI:  return {imm[11:0], rs1, 3'd7, rd, 7'h13};
      K_SLLI:  return {7'h00, imm[4:0], rs1, 3'd1, rd, 7'h13};
      K_SRLI:  return {7'h00, imm[4:0], rs1, 3'd5, rd, 7'h13};
      K_SRAI:  return {7'h20, imm[4:0], rs1, 3'd5, rd, 7'h13};
      K_LUI:   return {imm[19:0], rd, 7'h37};
      K_AUIPC: return {imm[19:0], rd, 7'h17};
      K_JAL:   return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
      K_JALR:  return {imm[11:0], rs1, 3'd0, rd, 7'h67};
      K_BEQ:   return {imm[12], imm[10:5], rs2, rs1, 3'd0, imm[4:1], imm[11], 7'h63};
      K_BNE:   return {imm[12], imm[10:5], rs2, rs1, 3'd1, imm[4:1], imm[11], 7'h63};
      K_BLT:   return {imm[12], imm[10:5], rs2, rs1, 3'd4, imm[4:1], imm[11], 7'h63};
      K_BGE:   return {imm[12], imm[10:5], rs2, rs1, 3'd5, imm[4:1], imm[11], 7'h63};
      K_BLTU:  return {imm[12], imm[10:5], rs2, rs1, 3'd6, imm[4:1], imm[11], 7'h63};
      K_BGEU:  return {imm[12], imm[10:5], rs2, rs1, 3'd7, imm[4:1], imm[11], 7'h63};
      default: return 32'h0000_0073;
    endcase
  endfunction

  // ISA-level reference: imm is already the sign-extended value (upper-20 value for LUI/AUIPC)
  task automatic model(input int k, input logic [4:0] rd, rs1, rs2, input logic [31:0] imm, pc,
                       output logic [31:0] npc, output logic we, output logic [31:0] val,
                       output int lat);
    logic [31:0] a, b;
    int shamt;
    a = mregs[rs1]; b = mregs[rs2];
    npc = pc + 32'd4; we = 1'b1; val = 32'd0; shamt = 0;
    case (k)
      K_ADD:   val = a + b;
      K_SUB:   val = a - b;
      K_SLL:   begin val = a << b[4:0]; shamt = int'(b[4:0]); end
      K_SLT:   val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      K_SLTU:  val = (a < b) ? 32'd1 : 32'd0;
      K_XOR:   val = a ^ b;
      K_SRL:   begin val = a >> b[4:0]; shamt = int'(b[4:0]); end
      K_SRA:   begin val = $signed(a) >>> b[4:0]; shamt = int'(b[4:0]); end
      K_OR:    val = a | b;
      K_AND:   val = a & b;
      K_ADDI:  val = a + imm;
      K_SLTI:  val = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
      K_SLTIU: val = (a < imm) ? 32'd1 : 32'd0;
      K_XORI:  val = a ^ imm;
      K_ORI:   val = a | imm;
      K_ANDI:  val = a & imm;
      K_SLLI:  begin val = a << imm[4:0]; shamt = int'(imm[4:0]); end
      K_SRLI:  begin val = a >> imm[4:0]; shamt = int'(imm[4:0]); end
      K_SRAI:  begin val = $signed(a) >>> imm[4:0]; shamt = int'(imm[4:0]); end
      K_LUI:   val = imm << 12;
      K_AUIPC: val = pc + (imm << 12);
      K_JAL:   begin val = pc + 32'd4; npc = pc + imm; end
      K_JALR:  begin val = pc + 32'd4; npc = (a + imm) & ~32'd1; end
      K_BEQ:   begin we = 1'b0; if (a == b) npc = pc + imm; end
      K_BNE:   begin we = 1'b0; if (a != b) npc = pc + imm; end
      K_BLT:   begin we = 1'b0; if ($signed(a) < $signed(b)) npc = pc + imm; end
      K_BGE:   begin we = 1'b0; if ($signed(a) >= $signed(b)) npc = pc + imm; end
      K_BLTU:  begin we = 1'b0; if (a < b) npc = pc + imm; end
      K_BGEU:  begin we = 1'b0; if (a >= b) npc = pc + imm; end
      default: we = 1'b0;
    endcase
    we = we && (rd != 5'd0);
    lat = 3;
`ifdef RV32I_SERIAL_SHIFT_EN
    lat = 3 + shamt;
`endif
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!instr_ready && n < 40) begin @(negedge clk); n++; end
  endtask

  task automatic run(input int k, input logic [4:0] rd, rs1, rs2, input logic [31:0] imm, pc,
                     input string tag);
    logic [31:0] enpc, eval;
    logic ewe, early_we;
    int elat, lat;
    model(k, rd, rs1, rs2, imm, pc, enpc, ewe, eval, elat);
    wait_ready();
    check_eq({tag, "_ready"}, 32'(instr_ready), 32'd1);
    instr = encode(k, rd, rs1, rs2, imm); instr_pc = pc; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = $urandom; instr_pc = $urandom;
    lat = 0; early_we = 1'b0;
    do begin
      @(negedge clk); lat++;
      if (wb_we && !next_pc_valid) early_we = 1'b1;
    end while (!next_pc_valid && lat < 80);
    obs_npc = next_pc; obs_we = wb_we; obs_data = wb_data; obs_lat = lat;
    check_eq({tag, "_lat"}, 32'(lat), 32'(elat));
    check_eq({tag, "_npc"}, next_pc, enpc);
    check_eq({tag, "_we"}, 32'(wb_we), 32'(ewe));
    check_eq({tag, "_early_we"}, 32'(early_we), 32'd0);
    if (ewe) begin
      check_eq({tag, "_id"}, 32'(wb_id), 32'(rd));
      check_eq({tag, "_data"}, wb_data, eval);
      mregs[rd] = eval;
    end
    @(negedge clk);
    check_eq({tag, "_pulse"}, 32'(next_pc_valid), 32'd0);
    check_eq({tag, "_ready_again"}, 32'(instr_ready), 32'd1);
    check_eq({tag, "_dbg"}, dbg_reg, mregs[1]);
  endtask

  task automatic halt_test(input logic [31:0] w, input string tag);
    int pulses;
    logic rdy_seen;
    wait_ready();
    instr = w; instr_pc = 32'h8; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr = 32'h0010_0093;  // addi x1,x0,1 offered while halted
    pulses = 0; rdy_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (next_pc_valid) pulses++;
      if (instr_ready) rdy_seen = 1'b1;
    end
    check_eq({tag, "_halted"}, 32'(halted), 32'd1);
    check_eq({tag, "_no_npc"}, 32'(pulses), 32'd0);
    check_eq({tag, "_no_ready"}, 32'(rdy_seen), 32'd0);
    instr_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq({tag, "_halt_clr"}, 32'(halted), 32'd0);
    #1 check_eq({tag, "_ready_rst"}, 32'(instr_ready), 32'd1);
    check_eq({tag, "_x1_kept"}, dbg_reg, mregs[1]);
  endtask

  function automatic logic [31:0] gen_imm(input int k);
    logic [31:0] r;
    r = $urandom;
    if (k >= K_SLLI && k <= K_SRAI) return {27'd0, r[4:0]};
    if (k == K_LUI || k == K_AUIPC) return {12'd0, r[19:0]};
    if (k == K_JAL) return {{11{r[20]}}, r[20:1], 1'b0};
    if (k >= K_BEQ) return {{19{r[12]}}, r[12:1], 1'b0};
    return {{20{r[11]}}, r[11:0]};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, pulses;
    logic we_seen;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    reset = 1'b1; instr_valid = 1'b0; instr = 32'd0; instr_pc = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_npc", next_pc, 32'd0);
    check_eq("rst_npv", 32'(next_pc_valid), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_we", 32'(wb_we), 32'd0);
    check_eq("rst_id", 32'(wb_id), 32'd0);
    check_eq("rst_data", wb_data, 32'd0);
    check_eq("rst_ready", 32'(instr_ready), 32'd0);
    reset = 1'b0;
    #1 check_eq("ready_after_rst", 32'(instr_ready), 32'd1);

    run(K_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0, "addi5");
    check_eq("addi5_val", obs_data, 32'd5);
    check_eq("addi5_npc4", obs_npc, 32'd4);
    check_eq("addi5_lat3", 32'(obs_lat), 32'd3);
    check_eq("addi5_dbg", dbg_reg, 32'd5);
    run(K_SUB, 5'd2, 5'd0, 5'd1, 32'd0, 32'h4, "sub");
    check_eq("sub_val", obs_data, 32'hFFFF_FFFB);
    run(K_SRAI, 5'd3, 5'd2, 5'd0, 32'd1, 32'h8, "srai");
    check_eq("srai_val", obs_data, 32'hFFFF_FFFD);
`ifdef RV32I_SERIAL_SHIFT_EN
    check_eq("srai_lat", 32'(obs_lat), 32'd4);
`else
    check_eq("srai_lat", 32'(obs_lat), 32'd3);
`endif
    run(K_ADDI, 5'd1, 5'd0, 5'd0, 32'd7, 32'h10, "x1_7");
    run(K_ADDI, 5'd2, 5'd0, 5'd0, 32'd7, 32'h14, "x2_7");
    run(K_BEQ, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 32'h20, "beq");
    check_eq("beq_target", obs_npc, 32'h18);
    check_eq("beq_no_we", 32'(obs_we), 32'd0);
    run(K_BNE, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 32'h20, "bne");
    check_eq("bne_fall", obs_npc, 32'h24);
    run(K_ADDI, 5'd5, 5'd0, 5'd0, 32'h101, 32'h30, "x5");
    run(K_JALR, 5'd5, 5'd5, 5'd0, 32'd0, 32'h40, "jalr");
    check_eq("jalr_target", obs_npc, 32'h100);
    check_eq("jalr_link", obs_data, 32'h44);
    run(K_ADD, 5'd1, 5'd5, 5'd0, 32'd0, 32'h100, "read_x5");
    check_eq("x5_val", obs_data, 32'h44);
    run(K_ADDI, 5'd0, 5'd0, 5'd0, 32'd9, 32'h104, "addi_x0");
    check_eq("x0_no_we", 32'(obs_we), 32'd0);
    run(K_ADD, 5'd1, 5'd0, 5'd0, 32'd0, 32'h108, "read_x0");
    check_eq("x0_zero", obs_data, 32'd0);

    // give every register a known random value, then plant corner values
    for (int r = 1; r < 32; r++) begin
      run(K_LUI, 5'(r), 5'd0, 5'd0, gen_imm(K_LUI), 32'h200, "init_lui");
      run(K_ADDI, 5'(r), 5'(r), 5'd0, gen_imm(K_ADDI), 32'h204, "init_addi");
    end
    run(K_LUI, 5'd31, 5'd0, 5'd0, 32'h80000, 32'h300, "c_min");
    run(K_ADDI, 5'd30, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h304, "c_m1");
    run(K_ADDI, 5'd29, 5'd0, 5'd0, 32'd0, 32'h308, "c_zero");
    run(K_ADDI, 5'd28, 5'd31, 5'd0, 32'hFFFF_FFFF, 32'h30C, "c_max");

    for (int i = 0; i < 250; i++) begin
      k = $urandom_range(0, 28);
      run(k, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
          gen_imm(k), $urandom & 32'hFFFF_FFFC, $sformatf("rnd%0d_k%0d", i, k));
    end

    // reset while addi x1,x1,1 is in EXEC
    wait_ready();
    instr = encode(K_ADDI, 5'd1, 5'd1, 5'd0, 32'd1); instr_pc = 32'h400; instr_valid = 1'b1;
    @(posedge clk); #1 instr_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pulses = 0; we_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (next_pc_valid) pulses++;
      if (wb_we) we_seen = 1'b1;
    end
    check_eq("midrst_ready", 32'(instr_ready), 32'd1);
    check_eq("midrst_no_npc", 32'(pulses), 32'd0);
    check_eq("midrst_no_we", 32'(we_seen), 32'd0);
    check_eq("midrst_x1", dbg_reg, mregs[1]);

    halt_test(32'h0000_2083, "lw");
    halt_test(32'h0010_2023, "sw");
    halt_test(32'h0000_0073, "ecall");
    halt_test(32'h0000_000B, "unknown");
    run(K_ADDI, 5'd1, 5'd1, 5'd0, 32'd3, 32'h500, "after_halt");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
